// File: rtl/regfile_writeback_pkg.sv
// Shared widths and source-select encoding for the write-back stage.
package regfile_writeback_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 5;
  localparam int unsigned WB_DATA_WIDTH = 32;

  // Which producer, if any, is accepted in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  // True when an index names a real destination (x0 is hardwired zero).
  function automatic logic is_writable(input logic [WB_ADDR_WIDTH-1:0] idx);
    return (idx != '0);
  endfunction

endpackage

// File: rtl/regfile_writeback_scoreboard.sv
// Per-register pending bits with hazard lookup for the issue stage.
module wb_scoreboard
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_idx_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_idx_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  output logic                  hazard_c_o
);

  localparam int unsigned NUM_REGS = 32'(1) << ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear on commit, then set on issue so a same-edge set wins; x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_idx_i] = 1'b0;
    end
    if (set_i) begin
      pending_d[set_idx_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // RAW on either source or WAW on the destination blocks issue.
  always_comb begin
    hazard_c_o = pending_q[rs1_i] | pending_q[rs2_i] | pending_q[rd_i];
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: LSU-over-ALU arbitration, registered RF write port,
// and a pending-bit scoreboard that stalls issue on RAW/WAW hazards.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // issue stage
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] iss_rs1,
  input  logic [ADDR_WIDTH-1:0] iss_rs2,
  output logic                  iss_ready,
  // ALU result
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  // LSU result
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  // register-file write port
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] dataD
);

  wb_src_e               sel_c;
  logic                  hazard_c;
  logic                  iss_fire_c;
  logic                  wen_q,  wen_d;
  logic [ADDR_WIDTH-1:0] rd_q,   rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Fixed priority LSU > ALU; readies depend only on the other producer.
  always_comb begin
    sel_c     = SRC_NONE;
    lsu_ready = 1'b1;
    alu_ready = ~lsu_valid;
    if (lsu_valid) begin
      sel_c = SRC_LSU;
    end else if (alu_valid) begin
      sel_c = SRC_ALU;
    end
  end

  // Capture the accepted result; writes to x0 handshake without a write.
  always_comb begin
    wen_d  = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    case (sel_c)
      SRC_LSU: begin
        rd_d   = lsu_rd;
        data_d = lsu_data;
        wen_d  = (lsu_rd != '0);
      end
      SRC_ALU: begin
        rd_d   = alu_rd;
        data_d = alu_data;
        wen_d  = (alu_rd != '0);
      end
      default: begin
        wen_d = 1'b0;
      end
    endcase
  end

  // Registered write port; reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign wen   = wen_q;
  assign rd    = rd_q;
  assign dataD = data_q;

  // Issue handshake; only a non-zero destination marks a register pending.
  always_comb begin
    iss_ready  = ~hazard_c;
    iss_fire_c = iss_valid & ~hazard_c;
  end

  // Pending bit clears on the edge the register file commits the write.
  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (iss_fire_c && (iss_rd != '0)),
    .set_idx_i  (iss_rd),
    .clr_i      (wen_q),
    .clr_idx_i  (rd_q),
    .rs1_i      (iss_rs1),
    .rs2_i      (iss_rs2),
    .rd_i       (iss_rd),
    .hazard_c_o (hazard_c)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based write-port scoreboard.
module tb_regfile_writeback;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic          iss_ready;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wen;
  logic [AW-1:0] rd;
  logic [DW-1:0] dataD;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  regfile_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .wen       (wen),
    .rd        (rd),
    .dataD     (dataD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write presented on the RF port must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd, dataD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", DW'(rd), DW'(e.rd));
        chk("wb_data", dataD, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    #2;
    chk("reset_wen", DW'(wen), 0);
    chk("reset_rd", DW'(rd), 0);
    chk("reset_data", dataD, 0);
    chk("reset_iss_ready", DW'(iss_ready), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1 chk("alu_ready_idle", DW'(alu_ready), 1);
    push(5'd5, 32'hDEAD_BEEF);
    tick();
    alu_valid = 1'b0;
    chk("single_wen_hi", DW'(wen), 1);
    tick();
    chk("single_wen_lo", DW'(wen), 0);
    chk("hold_rd", DW'(rd), 5);

    // contention: LSU first, ALU stalls then goes
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    #1;
    chk("contend_alu_ready", DW'(alu_ready), 0);
    chk("contend_lsu_ready", DW'(lsu_ready), 1);
    push(5'd4, 32'h22);
    tick();
    lsu_valid = 1'b0;
    #1 chk("alu_ready_after_lsu", DW'(alu_ready), 1);
    push(5'd3, 32'h11);
    tick();
    alu_valid = 1'b0;
    chk("contend_wen_2nd", DW'(wen), 1);
    tick();

    // write to x0: handshake completes, no RF write, rd/data captured
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1 chk("x0_alu_ready", DW'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    chk("x0_wen", DW'(wen), 0);
    chk("x0_rd", DW'(rd), 0);
    chk("x0_data", dataD, 32'h55);
    iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
    #1 chk("x0_no_pending", DW'(iss_ready), 1);
    tick();

    // scoreboard RAW stall on x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1 chk("issue7_ready", DW'(iss_ready), 1);
    tick();
    iss_rd = 5'd10; iss_rs1 = 5'd7;
    #1 chk("raw7_stall", DW'(iss_ready), 0);
    tick(); tick();
    chk("raw7_stall_hold", DW'(iss_ready), 0);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    push(5'd7, 32'h77);
    tick();
    alu_valid = 1'b0;
    chk("raw7_during_wen", DW'(iss_ready), 0);
    tick();
    chk("raw7_released", DW'(iss_ready), 1);
    iss_rs1 = 5'd10; iss_rd = 5'd0;
    #1 chk("stalled_issue_not_set", DW'(iss_ready), 1);
    iss_rs1 = 5'd0;
    tick();

    // set/clear collision on x9: unissued write commits while x9 issues
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    push(5'd9, 32'h99);
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1 chk("collide_issue_ready", DW'(iss_ready), 1);
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0; iss_rs2 = 5'd9;
    #1 chk("collide_set_wins", DW'(iss_ready), 0);
    tick();
    chk("collide_set_hold", DW'(iss_ready), 0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
    push(5'd9, 32'h9A);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("collide_cleared", DW'(iss_ready), 1);
    iss_rs2 = 5'd0;

    // back-to-back LSU writes keep wen high
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'hA1;
    push(5'd1, 32'hA1);
    tick();
    chk("b2b_wen_1", DW'(wen), 1);
    lsu_rd = 5'd2; lsu_data = 32'hA2;
    push(5'd2, 32'hA2);
    tick();
    lsu_valid = 1'b0;
    chk("b2b_wen_2", DW'(wen), 1);
    tick();

    // async reset mid write-back drops the write and pending bits
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hCC;
    tick();
    alu_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wen", DW'(wen), 0);
    chk("midrst_rd", DW'(rd), 0);
    chk("midrst_data", dataD, 0);
    iss_rs1 = 5'd12;
    #1 chk("midrst_pending_clr", DW'(iss_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_pending", DW'(iss_ready), 1);
    iss_rs1 = 5'd0;
    tick(); tick();

    chk("queue_drained", DW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
